// File: rtl/mtimer.sv
// Machine timer: 64-bit free-running mtime, mtimecmp and a level interrupt,
// exposed on an AXI4-lite slave port with 64-bit data.
module mtimer #(
    parameter int unsigned          TICK_DIV  = 1,
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_MASK = 'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp,
    output logic              mtime_int,
    output logic [63:0]       mtime_value
);

    localparam int unsigned       PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PrescLast = PW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] OffTime   = '0;
    localparam logic [ADDR_W-1:0] OffCmp    = ADDR_W'(8);
    localparam logic [1:0]        RespOkay  = 2'b00;
    localparam logic [1:0]        RespSlverr = 2'b10;

    typedef enum logic {WIdle, WResp} w_state_e;
    typedef enum logic {RIdle, RResp} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       cmp_q, cmp_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              int_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [63:0]       rdata_q, rdata_d;
    logic              tick, w_fire, r_fire;
    logic [ADDR_W-1:0] aw_off, ar_off;
    logic              aw_time, aw_cmp, ar_time, ar_cmp;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                          input logic [7:0] strb);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

    assign aw_off  = awaddr & BASE_MASK;
    assign ar_off  = araddr & BASE_MASK;
    assign aw_time = (aw_off == OffTime);
    assign aw_cmp  = (aw_off == OffCmp);
    assign ar_time = (ar_off == OffTime);
    assign ar_cmp  = (ar_off == OffCmp);

    assign tick    = (presc_q == PrescLast);
    assign presc_d = tick ? '0 : presc_q + PW'(1);
    assign w_fire  = awready;
    assign r_fire  = arready && arvalid;

    // A software write to mtime wins over the tick; untouched bytes keep the pre-tick value.
    always_comb begin
        mtime_d = mtime_q + 64'(tick);
        cmp_d   = cmp_q;
        if (w_fire && aw_time) mtime_d = merge(mtime_q, wdata, wstrb);
        if (w_fire && aw_cmp)  cmp_d   = merge(cmp_q, wdata, wstrb);
    end

    always_comb begin
        rdata_d = '0;
        if (ar_time)     rdata_d = mtime_q;
        else if (ar_cmp) rdata_d = cmp_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= WIdle;
            r_state_q <= RIdle;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            WIdle: if (w_fire) w_state_d = WResp;
            WResp: if (bready) w_state_d = WIdle;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            RIdle: if (r_fire) r_state_d = RResp;
            RResp: if (rready) r_state_d = RIdle;
        endcase
    end

    // AW and W are only accepted together so both handshakes land in one cycle.
    always_comb begin
        awready = 1'b0;
        if (rst && (w_state_q == WIdle)) awready = awvalid && wvalid;
        wready  = awready;
        arready = rst && (r_state_q == RIdle);
        bvalid  = (w_state_q == WResp);
        rvalid  = (r_state_q == RResp);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q <= '0;
            cmp_q   <= '1;
            presc_q <= '0;
            int_q   <= 1'b0;
            bresp_q <= RespOkay;
            rresp_q <= RespOkay;
            rdata_q <= '0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            presc_q <= presc_d;
            int_q   <= (mtime_q >= cmp_q);
            if (w_fire) bresp_q <= (aw_time || aw_cmp) ? RespOkay : RespSlverr;
            if (r_fire) begin
                rdata_q <= rdata_d;
                rresp_q <= (ar_time || ar_cmp) ? RespOkay : RespSlverr;
            end
        end
    end

    assign bresp       = bresp_q;
    assign rresp       = rresp_q;
    assign rdata       = rdata_q;
    assign mtime_int   = int_q;
    assign mtime_value = mtime_q;

endmodule

// File: tb/tb_mtimer.sv
// Randomized bench for mtimer with a cycle-level behavioural model and per-cycle compare.
module tb_mtimer;

    localparam int unsigned TICK_DIV = 4;
    localparam logic [31:0] MASK     = 32'h1F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, mtime_int;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata, mtime_value;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [63:0] m_mtime = '0, m_cmp = '1, m_rdata = '0;
    logic        m_int = 1'b0, m_wbusy = 1'b0, m_rbusy = 1'b0;
    logic [1:0]  m_bresp = '0, m_rresp = '0;
    int unsigned m_cyc = 0;

    mtimer #(.TICK_DIV(TICK_DIV), .ADDR_W(32), .BASE_MASK(MASK)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .mtime_int(mtime_int), .mtime_value(mtime_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] apply_strb(input logic [63:0] old, input logic [63:0] data,
                                               input logic [7:0] strb);
        logic [63:0] m = '0;
        for (int i = 0; i < 8; i++) if (strb[i]) m = m | (64'hFF << (8 * i));
        return (old & ~m) | (data & m);
    endfunction

    task automatic model_reset();
        m_mtime = '0; m_cmp = '1; m_rdata = '0; m_int = 1'b0;
        m_wbusy = 1'b0; m_rbusy = 1'b0; m_bresp = '0; m_rresp = '0; m_cyc = 0;
    endtask

    task automatic model_step();
        logic [63:0] t0, c0;
        logic [31:0] off;
        logic        tk, aw_acc, ar_acc;
        t0 = m_mtime;
        c0 = m_cmp;
        tk = ((m_cyc % TICK_DIV) == (TICK_DIV - 1));
        m_cyc++;
        aw_acc = !m_wbusy && awvalid && wvalid;
        ar_acc = !m_rbusy && arvalid;
        m_int = (t0 >= c0);
        m_mtime = t0 + 64'(tk);
        if (ar_acc) begin
            off = araddr & MASK;
            m_rbusy = 1'b1;
            m_rresp = 2'b00;
            if (off == 32'h0)      m_rdata = t0;
            else if (off == 32'h8) m_rdata = c0;
            else begin m_rdata = '0; m_rresp = 2'b10; end
        end else if (m_rbusy && rready) m_rbusy = 1'b0;
        if (aw_acc) begin
            off = awaddr & MASK;
            m_wbusy = 1'b1;
            m_bresp = 2'b00;
            if (off == 32'h0)      m_mtime = apply_strb(t0, wdata, wstrb);
            else if (off == 32'h8) m_cmp = apply_strb(c0, wdata, wstrb);
            else m_bresp = 2'b10;
        end else if (m_wbusy && bready) m_wbusy = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        check("mtime_value", mtime_value, m_mtime);
        check("mtime_int", 64'(mtime_int), 64'(m_int));
        check("bvalid", 64'(bvalid), 64'(m_wbusy));
        check("rvalid", 64'(rvalid), 64'(m_rbusy));
        check("bresp", 64'(bresp), 64'(m_bresp));
        check("rresp", 64'(rresp), 64'(m_rresp));
        check("rdata", rdata, m_rdata);
        check("awready", 64'(awready), 64'(rst && !m_wbusy && awvalid && wvalid));
        check("wready", 64'(wready), 64'(rst && !m_wbusy && awvalid && wvalid));
        check("arready", 64'(arready), 64'(rst && !m_rbusy));
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_value(input logic [63:0] v, input string name);
        int k = 0;
        while (mtime_value !== v && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, mtime_value, v);
    endtask

    logic [31:0] addrs [8] = '{32'h0, 32'h8, 32'h4, 32'h18, 32'h100, 32'h108, 32'h10, 32'hC};

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("tick_seq", mtime_value, 64'(k == 4));
            check("tick_int", 64'(mtime_int), 64'd0);
        end

        // mtimecmp = 0x10, interrupt rises one cycle after mtime reaches it
        drive_edge();
        awvalid = 1; wvalid = 1; awaddr = 32'h8; wdata = 64'h10; wstrb = 8'hFF; bready = 1;
        @(negedge clk); check("cmp_awready", 64'(awready), 64'd1);
        drive_edge(); awvalid = 0; wvalid = 0;
        @(negedge clk); check("cmp_bvalid", 64'(bvalid), 64'd1); check("cmp_bresp", 64'(bresp), 64'd0);
        wait_value(64'h10, "reach_10");
        check("int_before", 64'(mtime_int), 64'd0);
        @(negedge clk); check("int_rise", 64'(mtime_int), 64'd1);
        repeat (10) @(negedge clk);
        check("int_hold", 64'(mtime_int), 64'd1);

        // wrap
        drive_edge();
        awvalid = 1; wvalid = 1; awaddr = 32'h0; wdata = 64'hFFFF_FFFF_FFFF_FFFE; wstrb = 8'hFF;
        drive_edge(); awvalid = 0; wvalid = 0;
        @(negedge clk); check("mtime_written", mtime_value, 64'hFFFF_FFFF_FFFF_FFFE);
        wait_value(64'hFFFF_FFFF_FFFF_FFFF, "reach_max");
        wait_value(64'h0, "wrap_zero");
        check("wrap_int_old", 64'(mtime_int), 64'd1);
        @(negedge clk); check("wrap_int_fall", 64'(mtime_int), 64'd0);

        // decode errors
        drive_edge(); arvalid = 1; araddr = 32'h18; rready = 0;
        @(negedge clk); check("err_arready", 64'(arready), 64'd1);
        drive_edge(); arvalid = 0;
        @(negedge clk);
        check("err_rvalid", 64'(rvalid), 64'd1);
        check("err_rresp", 64'(rresp), 64'd2);
        check("err_rdata", rdata, 64'd0);
        drive_edge(); rready = 1;
        drive_edge(); rready = 0;
        awvalid = 1; wvalid = 1; awaddr = 32'h4; wdata = '1; wstrb = 8'hFF; bready = 0;
        drive_edge(); awvalid = 0; wvalid = 0;
        @(negedge clk); check("err_bresp", 64'(bresp), 64'd2);
        drive_edge(); bready = 1; arvalid = 1; araddr = 32'h8;
        drive_edge(); arvalid = 0;
        @(negedge clk); check("cmp_unchanged", rdata, 64'h10); check("cmp_rresp", 64'(rresp), 64'd0);
        drive_edge(); rready = 1;
        drive_edge(); rready = 0;

        // AW ahead of W, B back-pressure, second pair held off
        bready = 0; awvalid = 1; awaddr = 32'h8; wdata = 64'h40; wstrb = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("aw_wait", 64'(awready), 64'd0);
            drive_edge();
        end
        wvalid = 1;
        @(negedge clk); check("aw_w_join", 64'(awready), 64'd1);
        drive_edge(); wdata = 64'h80;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_hold_valid", 64'(bvalid), 64'd1);
            check("b_hold_resp", 64'(bresp), 64'd0);
            check("b_no_accept", 64'(awready), 64'd0);
            drive_edge();
        end
        bready = 1;
        @(negedge clk); check("b_hs_no_accept", 64'(awready), 64'd0);
        drive_edge();
        @(negedge clk); check("second_accept", 64'(awready), 64'd1);
        drive_edge(); awvalid = 0; wvalid = 0;
        @(negedge clk); check("second_bvalid", 64'(bvalid), 64'd1);
        drive_edge(); bready = 0;

        // reset, partial write, async reset mid-read
        rst = 0;
        @(negedge clk);
        check("rst_mtime", mtime_value, 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        drive_edge(); rst = 1;
        drive_edge(); awvalid = 1; wvalid = 1; awaddr = 32'h8; wdata = 64'h1234_5678;
        wstrb = 8'h0F; bready = 1;
        drive_edge(); awvalid = 0; wvalid = 0; arvalid = 1; araddr = 32'h8; rready = 0;
        drive_edge(); arvalid = 0;
        @(negedge clk); check("partial_rdata", rdata, 64'hFFFF_FFFF_1234_5678);
        check("partial_rvalid", 64'(rvalid), 64'd1);
        #2 rst = 0;
        #1 check("rvalid_async_rst", 64'(rvalid), 64'd0);
        drive_edge(); rst = 1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive_edge();
            awvalid = ($urandom_range(0, 2) != 0);
            wvalid  = ($urandom_range(0, 2) != 0);
            arvalid = ($urandom_range(0, 2) != 0);
            bready  = ($urandom_range(0, 1) != 0);
            rready  = ($urandom_range(0, 1) != 0);
            awaddr  = addrs[$urandom_range(0, 7)];
            araddr  = addrs[$urandom_range(0, 7)];
            wstrb   = 8'($urandom);
            case ($urandom_range(0, 3))
                0: wdata = 64'($urandom_range(0, 300));
                1: wdata = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 20));
                default: wdata = {$urandom, $urandom};
            endcase
            rst = ($urandom_range(0, 499) != 0);
        end

        drive_edge();
        rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
